// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: in-order pipe write request, long-latency unit
// result handshake, and the register-file write port driven by the arbiter.
interface wb_port_arbiter_if #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5
) ();
  logic                 pipe_wr_reg;
  logic [REGNOBITS-1:0] pipe_wregno;
  logic [DBITS-1:0]     pipe_regval;
  logic                 lu_valid;
  logic                 lu_ready;
  logic [REGNOBITS-1:0] lu_wregno;
  logic [DBITS-1:0]     lu_regval;
  logic                 wr_reg_WB;
  logic [REGNOBITS-1:0] wregno_WB;
  logic [DBITS-1:0]     regval_WB;
  logic                 stall_pipe;
  logic [1:0]           fifo_count;

  modport master (
    output pipe_wr_reg, pipe_wregno, pipe_regval,
    output lu_valid, lu_wregno, lu_regval,
    input  lu_ready, wr_reg_WB, wregno_WB, regval_WB, stall_pipe, fifo_count
  );

  modport slave (
    input  pipe_wr_reg, pipe_wregno, pipe_regval,
    input  lu_valid, lu_wregno, lu_regval,
    output lu_ready, wr_reg_WB, wregno_WB, regval_WB, stall_pipe, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single write-back port shared by the in-order pipe (always wins) and a
// long-latency unit buffered in a 2-entry FIFO with WAW squash and starvation stall.
module wb_port_arbiter #(
  parameter int DBITS        = 32,
  parameter int REGNOBITS    = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [REGNOBITS-1:0] REG_ZERO = {REGNOBITS{1'b0}};

  logic [1:0]           count_q, count_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic [REGNOBITS-1:0] wregno_q [2];
  logic [REGNOBITS-1:0] wregno_d [2];
  logic [DBITS-1:0]     regval_q [2];
  logic [DBITS-1:0]     regval_d [2];
  logic [1:0]           sq_q, sq_d;

  logic       ready_s, nonempty_s, enq_s, deq_s, squash_s;
  logic [1:0] slot_s;

  assign ready_s    = (count_q < 2'd2);
  assign nonempty_s = (count_q != 2'd0);
  assign enq_s      = bus.lu_valid && ready_s;
  assign deq_s      = !bus.pipe_wr_reg && nonempty_s;
  assign squash_s   = bus.pipe_wr_reg && (bus.pipe_wregno != REG_ZERO);
  assign slot_s     = deq_s ? (count_q - 2'd1) : count_q;

  assign bus.lu_ready   = ready_s;
  assign bus.fifo_count = count_q;
  assign bus.stall_pipe = (starve_q == STARVE_MAX);

  // Write port: pipe first, then FIFO head; squashed or x0 heads still consume the grant
  always_comb begin
    bus.wr_reg_WB = 1'b0;
    bus.wregno_WB = bus.pipe_wregno;
    bus.regval_WB = bus.pipe_regval;
    if (!reset) begin
      bus.wr_reg_WB = 1'b0;
    end else if (bus.pipe_wr_reg) begin
      bus.wr_reg_WB = (bus.pipe_wregno != REG_ZERO);
    end else if (nonempty_s) begin
      bus.wr_reg_WB = !sq_q[0] && (wregno_q[0] != REG_ZERO);
      bus.wregno_WB = wregno_q[0];
      bus.regval_WB = regval_q[0];
    end else begin
      bus.wr_reg_WB = 1'b0;
    end
  end

  // FIFO next state: squash resident matches, shift on dequeue, then append
  always_comb begin
    count_d = count_q + {1'b0, enq_s} - {1'b0, deq_s};
    sq_d    = sq_q;
    for (int i = 0; i < 2; i++) begin
      wregno_d[i] = wregno_q[i];
      regval_d[i] = regval_q[i];
      if (squash_s && (2'(i) < count_q) && (wregno_q[i] == bus.pipe_wregno)) begin
        sq_d[i] = 1'b1;
      end else begin
        sq_d[i] = sq_q[i];
      end
    end
    if (deq_s) begin
      wregno_d[0] = wregno_q[1];
      regval_d[0] = regval_q[1];
      sq_d[0]     = sq_q[1];
      sq_d[1]     = 1'b0;
    end else begin
      sq_d = sq_d;
    end
    if (enq_s) begin
      wregno_d[slot_s[0]] = bus.lu_wregno;
      regval_d[slot_s[0]] = bus.lu_regval;
      sq_d[slot_s[0]]     = 1'b0;
    end else begin
      sq_d = sq_d;
    end
  end

  // Starvation counter only runs while a resident head is being denied
  always_comb begin
    starve_d = starve_q;
    if (!nonempty_s || deq_s) begin
      starve_d = {SW{1'b0}};
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= 2'd0;
      starve_q <= {SW{1'b0}};
      sq_q     <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        wregno_q[i] <= REG_ZERO;
        regval_q[i] <= {DBITS{1'b0}};
      end
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      sq_q     <= sq_d;
      wregno_q <= wregno_d;
      regval_q <= regval_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter: a queue-based reference model is compared
// against the write port, FIFO status and stall on every cycle, plus directed scenarios.
module tb_wb_port_arbiter;
  localparam int DBITS        = 32;
  localparam int REGNOBITS    = 5;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DBITS(DBITS), .REGNOBITS(REGNOBITS)) bus ();

  wb_port_arbiter #(
    .DBITS(DBITS), .REGNOBITS(REGNOBITS), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [4:0]  regno;
    logic [31:0] val;
    bit          sq;
  } ent_t;

  ent_t mq[$];
  int   starve   = 0;
  int   n_tests  = 0;
  int   n_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected write-port and status outputs from the current model state and inputs
  task automatic model_check();
    logic        ewr;
    logic [4:0]  ern;
    logic [31:0] erv;
    ewr = 1'b0; ern = 5'd0; erv = 32'd0;
    if (reset && bus.pipe_wr_reg) begin
      ewr = (bus.pipe_wregno != 5'd0);
      ern = bus.pipe_wregno;
      erv = bus.pipe_regval;
    end else if (reset && mq.size() > 0) begin
      ewr = !mq[0].sq && (mq[0].regno != 5'd0);
      ern = mq[0].regno;
      erv = mq[0].val;
    end
    chk("wr_reg_WB", bus.wr_reg_WB, ewr);
    if (ewr) begin
      chk("wregno_WB", bus.wregno_WB, ern);
      chk("regval_WB", bus.regval_WB, erv);
    end
    chk("lu_ready", bus.lu_ready, mq.size() < 2);
    chk("stall_pipe", bus.stall_pipe, starve == STARVE_LIMIT);
    chk("fifo_count", bus.fifo_count, mq.size());
  endtask

  // Model state change at a rising edge
  task automatic model_update();
    bit   enq;
    ent_t e;
    if (!reset) begin
      mq.delete();
      starve = 0;
      return;
    end
    enq = bus.lu_valid && (mq.size() < 2);
    if (bus.pipe_wr_reg && bus.pipe_wregno != 5'd0)
      foreach (mq[i]) if (mq[i].regno == bus.pipe_wregno) mq[i].sq = 1'b1;
    if (mq.size() == 0) starve = 0;
    else if (!bus.pipe_wr_reg) begin
      void'(mq.pop_front());
      starve = 0;
    end else if (starve < STARVE_LIMIT) starve++;
    if (enq) begin
      e.regno = bus.lu_wregno;
      e.val   = bus.lu_regval;
      e.sq    = 1'b0;
      mq.push_back(e);
    end
  endtask

  task automatic apply(input logic rst, input logic pw, input logic [4:0] pn, input logic [31:0] pv,
                       input logic lv, input logic [4:0] ln, input logic [31:0] lval);
    @(negedge clk);
    reset           = rst;
    bus.pipe_wr_reg = pw;
    bus.pipe_wregno = pn;
    bus.pipe_regval = pv;
    bus.lu_valid    = lv;
    bus.lu_wregno   = ln;
    bus.lu_regval   = lval;
    if (!rst) begin
      mq.delete();
      starve = 0;
    end
    #1;
    model_check();
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle();
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Pipe hammers x3 while lu offers x10, x11, then x12 forever
  task automatic fill(input int n);
    for (int k = 0; k < n; k++) begin
      apply(1'b1, 1'b1, 5'd3, 32'h30 + k, 1'b1,
            (k == 0) ? 5'd10 : ((k == 1) ? 5'd11 : 5'd12), 32'h100 + k);
      commit();
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.pipe_wr_reg = 1'b0; bus.pipe_wregno = 5'd0; bus.pipe_regval = 32'd0;
    bus.lu_valid = 1'b0; bus.lu_wregno = 5'd0; bus.lu_regval = 32'd0;

    // reset forces the write port off even with a pipe request
    apply(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    chk("rst_wr", bus.wr_reg_WB, 1'b0);
    chk("rst_count", bus.fifo_count, 2'd0);
    chk("rst_ready", bus.lu_ready, 1'b1);
    chk("rst_stall", bus.stall_pipe, 1'b0);
    commit();

    // pipe write x5=0x11
    apply(1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
    chk("p_wr", bus.wr_reg_WB, 1'b1);
    chk("p_regno", bus.wregno_WB, 5'd5);
    chk("p_val", bus.regval_WB, 32'h11);
    chk("p_count", bus.fifo_count, 2'd0);
    commit();

    // lu x7=0xAB through the FIFO
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAB);
    chk("lu_ready0", bus.lu_ready, 1'b1);
    chk("lu_wr0", bus.wr_reg_WB, 1'b0);
    commit();
    idle();
    chk("lu_count1", bus.fifo_count, 2'd1);
    chk("lu_wr1", bus.wr_reg_WB, 1'b1);
    chk("lu_regno1", bus.wregno_WB, 5'd7);
    chk("lu_val1", bus.regval_WB, 32'hAB);
    commit();
    idle();
    chk("lu_count2", bus.fifo_count, 2'd0);
    commit();

    // starvation: fill, saturate, then drain
    fill(4);
    apply(1'b1, 1'b1, 5'd3, 32'h34, 1'b1, 5'd12, 32'h104);
    chk("st_ready_full", bus.lu_ready, 1'b0);
    chk("st_not_yet", bus.stall_pipe, 1'b0);
    commit();
    apply(1'b1, 1'b1, 5'd3, 32'h35, 1'b1, 5'd12, 32'h105);
    chk("st_stall", bus.stall_pipe, 1'b1);
    chk("st_count", bus.fifo_count, 2'd2);
    commit();
    idle();
    chk("st_drain_regno", bus.wregno_WB, 5'd10);
    chk("st_drain_val", bus.regval_WB, 32'h100);
    chk("st_drain_stall", bus.stall_pipe, 1'b1);
    commit();
    idle();
    chk("st_released", bus.stall_pipe, 1'b0);
    chk("st_second_regno", bus.wregno_WB, 5'd11);
    commit();
    idle();
    chk("st_empty", bus.fifo_count, 2'd0);
    commit();

    // WAW squash of resident x9
    apply(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h1);
    commit();
    apply(1'b1, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
    chk("waw_regno", bus.wregno_WB, 5'd9);
    chk("waw_val", bus.regval_WB, 32'h2);
    commit();
    idle();
    chk("waw_squashed_wr", bus.wr_reg_WB, 1'b0);
    chk("waw_count", bus.fifo_count, 2'd1);
    commit();
    idle();
    chk("waw_drained", bus.fifo_count, 2'd0);
    commit();

    // same-cycle enqueue is not squashed
    apply(1'b1, 1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 32'h1);
    commit();
    idle();
    chk("nosq_wr", bus.wr_reg_WB, 1'b1);
    chk("nosq_val", bus.regval_WB, 32'h1);
    commit();

    // lu write to x0 is consumed silently
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5);
    commit();
    idle();
    chk("x0_wr", bus.wr_reg_WB, 1'b0);
    chk("x0_count", bus.fifo_count, 2'd1);
    commit();
    idle();
    chk("x0_drained", bus.fifo_count, 2'd0);
    commit();

    // reset mid-operation with a full, stalled FIFO
    fill(6);
    apply(1'b0, 1'b1, 5'd3, 32'h36, 1'b1, 5'd12, 32'h106);
    chk("mr_count", bus.fifo_count, 2'd0);
    chk("mr_stall", bus.stall_pipe, 1'b0);
    chk("mr_ready", bus.lu_ready, 1'b1);
    chk("mr_wr", bus.wr_reg_WB, 1'b0);
    commit();
    idle();
    chk("mr_after_wr", bus.wr_reg_WB, 1'b0);
    chk("mr_after_count", bus.fifo_count, 2'd0);
    commit();

    // randomized traffic, small register range to provoke squash and x0 cases
    for (int c = 0; c < 3000; c++) begin
      logic rst_v, pw;
      rst_v = ($urandom_range(0, 199) != 0);
      if (starve == STARVE_LIMIT) pw = ($urandom_range(0, 7) == 0);
      else pw = ($urandom_range(0, 2) != 0);
      apply(rst_v, pw, 5'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      commit();
    end
    for (int c = 0; c < 4; c++) begin
      idle();
      commit();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DBITS, 32, register data width.
REQ-002 Parameter REGNOBITS, 5, register number width.
REQ-003 Parameter STARVE_LIMIT, 4, consecutive denied cycles before the pipeline bubble request.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-006 pipe_wr_reg  in  1  in-order pipe (MEM latch) requests a register write this cycle.
REQ-007 pipe_wregno  in  REGNOBITS  in-order pipe destination register.
REQ-008 pipe_regval  in  DBITS  in-order pipe write data.
REQ-009 lu_valid  in  1  long-latency unit offers a result.
REQ-010 lu_ready  out  1  arbiter accepts the lu result this cycle.
REQ-011 lu_wregno  in  REGNOBITS  long-latency unit destination register.
REQ-012 lu_regval  in  DBITS  long-latency unit write data.
REQ-013 wr_reg_WB  out  1  register-file write enable (to DE).
REQ-014 wregno_WB  out  REGNOBITS  register-file write index.
REQ-015 regval_WB  out  DBITS  register-file write data.
REQ-016 stall_pipe  out  1  request to upstream: present no pipe write next cycle.
REQ-017 fifo_count  out  2  current lu holding-FIFO occupancy (0..2), debug.

Function
REQ-018 The block SHALL hold lu results in a 2-entry in-order FIFO of {wregno, regval, squashed}.
REQ-019 lu_ready SHALL equal (fifo_count < 2), from registered state only; no combinational path from any input.
REQ-020 Enqueue SHALL occur on lu_valid && lu_ready; an enqueued entry is eligible for grant no earlier than the following cycle.
REQ-021 Grant priority: pipe_wr_reg=1 -> outputs carry pipe fields; else FIFO non-empty -> outputs carry head, head dequeued that cycle; else wr_reg_WB=0.
REQ-022 Write outputs SHALL be combinational (zero latency) from inputs and FIFO head.
REQ-023 Writes to register 0 SHALL drive wr_reg_WB=0; a granted FIFO head with wregno 0 is still dequeued.
REQ-024 WAW squash: when pipe_wr_reg=1 with pipe_wregno!=0, every FIFO entry already resident with matching wregno SHALL have squashed set at that edge; an entry enqueued the same cycle is not squashed.
REQ-025 A granted squashed head SHALL be dequeued with wr_reg_WB=0, consuming the slot.
REQ-026 Enqueue and dequeue in the same cycle SHALL leave fifo_count unchanged.
REQ-027 starve_cnt (width to hold STARVE_LIMIT): increments, saturating at STARVE_LIMIT, each cycle FIFO non-empty and head denied by pipe_wr_reg=1; clears on head dequeue or when FIFO empty.
REQ-028 stall_pipe SHALL equal (starve_cnt == STARVE_LIMIT), held until the head is dequeued.
REQ-029 If pipe_wr_reg=1 while stall_pipe=1 (upstream violation), the pipe SHALL still win and starve_cnt stays saturated.

Reset
REQ-030 While reset=0: FIFO empty, squashed bits 0, starve_cnt 0, fifo_count 0, stall_pipe 0, lu_ready 1, wr_reg_WB 0 (forced regardless of pipe_wr_reg).
REQ-031 Reset asserted mid-operation SHALL discard all FIFO contents without producing a write; first grant after release uses only post-release inputs.

Verification
REQ-032 Idle lu; pipe writes x5=0x11 -> same cycle wr_reg_WB=1, wregno_WB=5, regval_WB=0x11; fifo_count 0.
REQ-033 pipe idle; lu offers x7=0xAB cycle 0 -> lu_ready=1, fifo_count=1 cycle 1, write x7=0xAB in cycle 1, fifo_count=0 cycle 2.
REQ-034 pipe_wr_reg=1 continuously, lu offers 3 results -> first two enqueued, lu_ready=0 at count 2, stall_pipe=1 after 4 denied cycles; dropping pipe_wr_reg drains head, stall_pipe=0 next cycle.
REQ-035 FIFO holds x9=0x1; pipe writes x9=0x2 -> x9=0x2 written; next idle cycle head dequeued with wr_reg_WB=0; final x9=0x2.
REQ-036 lu offers x0=0x5, pipe idle -> dequeued, wr_reg_WB=0.
REQ-037 FIFO count 2 with stall_pipe=1, reset pulsed low -> immediately fifo_count=0, stall_pipe=0, lu_ready=1, no write after release.
